// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

    localparam logic [31:0] DEF_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] DEF_CON_ADDR = 32'h4000_0020;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_IRQ   = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart by comparing the MSBs. A push while full is accepted
// only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // Next pointer values; natural wrap is modulo 2*DEPTH.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array, no reset needed since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: TXD stores feed a byte FIFO, a baud
// FSM serialises bytes on tx, CON reports status and clears sticky flags.
// Optional TX-empty interrupt enabled by defining UART_TX_IRQ_EN.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (tx=0) for BAUD_DIV cycles
// DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// STOP  | stop bit (tx=1); chains straight into START if more bytes wait
module uart_tx_peripheral
    import uart_pkg::*;
#(
    parameter int          BAUD_DIV   = 5208,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] TXD_ADDR   = DEF_TXD_ADDR,
    parameter logic [31:0] CON_ADDR   = DEF_CON_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        tx,
    output logic        irqout
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    tx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        ovf_q;
    logic        irq_pending;

    logic        txd_wr, con_wr, con_rd;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic        baud_last;
    logic [31:0] status;
    logic        unused_wdata;

    assign txd_wr    = MemWrite && (Address == TXD_ADDR);
    assign con_wr    = MemWrite && (Address == CON_ADDR);
    assign con_rd    = MemRead  && (Address == CON_ADDR);
    assign baud_last = (baud_q == BAUD_LAST);
    assign unused_wdata = ^Write_data[31:8];

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (txd_wr),
        .pop_i   (fifo_pop),
        .din_i   (Write_data[7:0]),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Baud FSM next-state: pops a byte on leaving IDLE or at the end of STOP.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        bit_d    = '0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers; reset returns the line to idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Line driver decoded from state so reset forces tx high asynchronously.
    always_comb begin
        tx = 1'b1;
        if (state_q == START)     tx = 1'b0;
        else if (state_q == DATA) tx = shift_q[0];
    end

    // Sticky overflow: a dropped byte wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (txd_wr && fifo_full && !fifo_pop)
            ovf_q <= 1'b1;
        else if (con_wr && Write_data[STAT_OVF])
            ovf_q <= 1'b0;
    end

`ifdef UART_TX_IRQ_EN
    logic irq_q;
    logic frame_done;

    assign frame_done = (state_q == STOP) && baud_last && fifo_empty;

    // TX-empty interrupt, raised as the FSM drops back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_q <= 1'b0;
        else if (frame_done)
            irq_q <= 1'b1;
        else if (con_wr && Write_data[STAT_IRQ])
            irq_q <= 1'b0;
    end

    assign irq_pending = irq_q;
    assign irqout      = irq_q;
`else
    assign irq_pending = 1'b0;
    assign irqout      = 1'b0;
`endif

    // Status word and read mux; only CON returns non-zero data.
    always_comb begin
        status             = '0;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_BUSY]  = (state_q != IDLE);
        status[STAT_OVF]   = ovf_q;
        status[STAT_IRQ]   = irq_pending;
        Read_data          = con_rd ? status : 32'd0;
    end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Directed bench for uart_tx_peripheral at BAUD_DIV=4.
module tb_uart_tx_peripheral;

    localparam int          BD   = 4;
    localparam logic [31:0] TXD  = 32'h4000_0018;
    localparam logic [31:0] CON  = 32'h4000_0020;
    localparam logic [31:0] UNM  = 32'h4000_0000;
`ifdef UART_TX_IRQ_EN
    localparam logic [31:0] IRQ_BIT = 32'h10;
    localparam logic        IRQ_ON  = 1'b1;
`else
    localparam logic [31:0] IRQ_BIT = 32'h0;
    localparam logic        IRQ_ON  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic        tx;
    logic        irqout;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_peripheral #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .tx         (tx),
        .irqout     (irqout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite   = 1'b1;
        Address    = a;
        Write_data = d;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
        Address    = '0;
        Write_data = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        MemRead = 1'b1;
        Address = a;
        #1;
        d       = Read_data;
        MemRead = 1'b0;
        Address = '0;
    endtask

    task automatic con_is(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(CON, d);
        chk(tag, d, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Caller is positioned in frame cycle 0; returns positioned in cycle 40.
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [31:0] d;
        for (int j = 0; j < 10; j++) begin
            for (int s = 0; s < BD; s++) begin
                chk(tag, {31'd0, tx}, {31'd0, frame_bit(b, j)});
                if (s == 0) begin
                    bus_read(CON, d);
                    chk({tag, "_busy"}, {31'd0, d[2]}, 32'd1);
                end
                cyc();
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        logic [31:0] d;
        bit idle = 1'b0;
        for (int i = 0; i < max_cyc && !idle; i++) begin
            bus_read(CON, d);
            if (d[2] == 1'b0) idle = 1'b1;
            else cyc();
        end
        chk("idle_timeout", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int lows;

        // Reset state
        #3;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_irq", {31'd0, irqout}, 32'd0);
        con_is("rst_con", 32'h1);
        #10 rst_n = 1'b1;
        cyc();
        con_is("post_rst_con", 32'h1);

        // Single byte 0x55
        bus_write(TXD, 32'h55);
        chk("gap_tx", {31'd0, tx}, 32'd1);
        cyc();
        check_frame("f55", 8'h55);
        chk("f55_end_tx", {31'd0, tx}, 32'd1);
        chk("f55_irq", {31'd0, irqout}, {31'd0, IRQ_ON});
        con_is("f55_end_con", 32'h1 | IRQ_BIT);
        bus_write(CON, 32'h10);
        chk("irq_clr", {31'd0, irqout}, 32'd0);
        con_is("irq_clr_con", 32'h1);

        // FIFO fill and overflow
        for (int i = 1; i <= 5; i++) bus_write(TXD, 32'(i));
        con_is("fill5_con", 32'h6);
        bus_write(TXD, 32'h06);
        con_is("ovf_con", 32'hE);
        MemRead    = 1'b1;
        MemWrite   = 1'b1;
        Address    = CON;
        Write_data = 32'h8;
        #1;
        chk("rw_pre_edge", Read_data, 32'hE);
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Address  = '0;
        con_is("ovf_clr_con", 32'h6);
        wait_idle(300);
        bus_write(CON, 32'h10);
        con_is("drain_con", 32'h1);

        // Back-to-back frames
        bus_write(TXD, 32'hA0);
        bus_write(TXD, 32'h0F);
        check_frame("fA0", 8'hA0);
        check_frame("f0F", 8'h0F);
        chk("b2b_end_tx", {31'd0, tx}, 32'd1);
        con_is("b2b_end_con", 32'h1 | IRQ_BIT);
        bus_write(CON, 32'h10);

        // Reset mid-DATA
        bus_write(TXD, 32'h33);
        repeat (10) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_irq", {31'd0, irqout}, 32'd0);
        con_is("midrst_con", 32'h1);
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        con_is("postrst_con", 32'h1);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) lows++;
            cyc();
        end
        chk("postrst_quiet", 32'(lows), 32'd0);

        // Read and unmapped-address behaviour
        bus_read(TXD, d);
        chk("txd_read", d, 32'd0);
        bus_read(UNM, d);
        chk("unm_read", d, 32'd0);
        bus_write(UNM, 32'h77);
        bus_write(32'h4000_001C, 32'h78);
        con_is("unm_wr_con", 32'h1);
        cyc();
        chk("unm_wr_tx", {31'd0, tx}, 32'd1);
        con_is("unm_wr_con2", 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
